// File: rtl/roach_rst_sequencer.sv
// roach_rst_sequencer: staged reset and bring-up sequencer for the board clock domains.
// Waits for all unmasked clock-manager locks to be stable, pulses idelay_rst,
// waits for idelay_rdy, then releases domain_rst one bit at a time.
// Ports:
//   sys_clk, sys_rst          free-running clock, async active-high reset
//   lock_in, lock_mask        lock flags (async) and monitor mask (1 = monitored)
//   idelay_rdy                IDELAYCTRL ready (async)
//   soft_rst                  one-cycle request to restart the sequence
//   idelay_rst, domain_rst    IDELAYCTRL reset and staged domain resets
//   all_ready, timeout_err    RUN indicator and sticky ready-timeout flag
//   seq_state, relock_count   FSM state and saturating count of lock losses in RUN
// Optional: define ROACH_RST_SEQ_RELOCK_CNT_EN to implement relock_count (else tied to 0).
module roach_rst_sequencer #(
    parameter int NUM_LOCKS          = 4,
    parameter int NUM_DOMAINS        = 3,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int IDELAY_RST_CYCLES  = 16,
    parameter int STAGE_GAP          = 64,
    parameter int RDY_TIMEOUT        = 4096
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [NUM_LOCKS-1:0]   lock_in,
    input  logic [NUM_LOCKS-1:0]   lock_mask,
    input  logic                   idelay_rdy,
    input  logic                   soft_rst,
    output logic                   idelay_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   all_ready,
    output logic                   timeout_err,
    output logic [2:0]             seq_state,
    output logic [7:0]             relock_count
);
    localparam int REL_LAST = (NUM_DOMAINS - 1) * STAGE_GAP;
    localparam int M1 = LOCK_STABLE_CYCLES > IDELAY_RST_CYCLES ? LOCK_STABLE_CYCLES : IDELAY_RST_CYCLES;
    localparam int M2 = RDY_TIMEOUT > REL_LAST ? RDY_TIMEOUT : REL_LAST;
    localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        IDLY_RST  = 3'd2,
        IDLY_WAIT = 3'd3,
        RELEASE   = 3'd4,
        RUN       = 3'd5,
        ERR       = 3'd6
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [NUM_LOCKS-1:0]   lock_meta, lock_sync;
    logic                   rdy_meta, rdy_sync;
    logic                   lock_ok, terr_nxt;
    logic [NUM_DOMAINS-1:0] released;

    // Unmonitored locks count as locked, so an all-zero mask reads as locked.
    assign lock_ok   = &(lock_sync | ~lock_mask);
    assign seq_state = state;

    // In RELEASE the shared counter is the time since the first release.
    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_rel
        assign released[g] = int'(cnt) >= g * STAGE_GAP;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            lock_meta   <= '0;
            lock_sync   <= '0;
            rdy_meta    <= 1'b0;
            rdy_sync    <= 1'b0;
            state       <= WAIT_LOCK;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            lock_meta   <= lock_in;
            lock_sync   <= lock_meta;
            rdy_meta    <= idelay_rdy;
            rdy_sync    <= rdy_meta;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            timeout_err <= terr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            WAIT_LOCK: state_nxt = lock_ok ? STABLE : WAIT_LOCK;
            STABLE:
                if (!lock_ok) state_nxt = WAIT_LOCK;
                else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) state_nxt = IDLY_RST;
                else cnt_nxt = cnt + 1'b1;
            IDLY_RST:
                if (!lock_ok) state_nxt = WAIT_LOCK;
                else if (cnt == CW'(IDELAY_RST_CYCLES - 1)) state_nxt = IDLY_WAIT;
                else cnt_nxt = cnt + 1'b1;
            // Ready is checked before the timeout so a same-cycle arrival wins.
            IDLY_WAIT:
                if (!lock_ok) state_nxt = WAIT_LOCK;
                else if (rdy_sync) state_nxt = RELEASE;
                else if (cnt == CW'(RDY_TIMEOUT - 1)) state_nxt = ERR;
                else cnt_nxt = cnt + 1'b1;
            RELEASE:
                if (!lock_ok) state_nxt = WAIT_LOCK;
                else if (cnt == CW'(REL_LAST)) state_nxt = RUN;
                else cnt_nxt = cnt + 1'b1;
            RUN:       state_nxt = lock_ok ? RUN : WAIT_LOCK;
            ERR:       state_nxt = ERR;
            default:   state_nxt = WAIT_LOCK;
        endcase
        if (soft_rst) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
        end
        terr_nxt   = soft_rst ? 1'b0 : (timeout_err | (state == IDLY_WAIT && state_nxt == ERR));
        idelay_rst = state == IDLY_RST;
        all_ready  = state == RUN;
        domain_rst = state == RUN ? '0 : state == RELEASE ? ~released : '1;
    end

`ifdef ROACH_RST_SEQ_RELOCK_CNT_EN
    logic [7:0] relock_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) relock_q <= '0;
        else if (state == RUN && !lock_ok && !soft_rst && relock_q != 8'hff) relock_q <= relock_q + 8'd1;
    end

    assign relock_count = relock_q;
`else
    assign relock_count = 8'd0;
`endif
endmodule

// File: doc/roach_rst_sequencer.md
Name: roach_rst_sequencer

Overview:
Parametrised reset and bring-up sequencer that sits downstream of the board clock infrastructure. It waits until every unmasked clock-manager lock is stable, then pulses the IDELAYCTRL reset and waits for its ready. It then releases per-domain resets in staged order, one domain at a time. On any lock loss it re-runs the whole sequence; it also provides a soft restart, a ready-timeout error and an optional relock counter.

Parameters:
NUM_LOCKS, 4, number of lock inputs monitored (1..16)
NUM_DOMAINS, 3, number of staged domain resets (1..8)
LOCK_STABLE_CYCLES, 1024, consecutive cycles all locks must hold before sequencing (>=2)
IDELAY_RST_CYCLES, 16, idelay_rst pulse width in cycles (>=1)
STAGE_GAP, 64, cycles between successive domain_rst releases (>=1)
RDY_TIMEOUT, 4096, cycles allowed for idelay_rdy after the pulse ends (>=2)

Ports:
sys_clk  in  1  sequencer clock (free-running, not derived from a monitored lock)
sys_rst  in  1  asynchronous, active-high reset
lock_in  in  NUM_LOCKS  lock flags from clock managers, asynchronous
lock_mask  in  NUM_LOCKS  1 = lock monitored; quasi-static, used unsynchronised
idelay_rdy  in  1  IDELAYCTRL ready, asynchronous
soft_rst  in  1  synchronous one-cycle request to restart the sequence
idelay_rst  out  1  IDELAYCTRL reset, active-high
domain_rst  out  NUM_DOMAINS  per-domain resets, active-high; bit 0 is released first
all_ready  out  1  high only in RUN
timeout_err  out  1  sticky idelay_rdy timeout flag
seq_state  out  3  current FSM state encoding
relock_count  out  8  lock-loss events seen in RUN, saturating

Behaviour:
- Reset values (sys_rst high): idelay_rst=0, domain_rst=all 1s, all_ready=0, timeout_err=0, seq_state=WAIT_LOCK, relock_count=0, all counters=0.
- lock_in and idelay_rdy each pass through a 2-flop synchroniser.
- lock_ok = AND over i of (lock_sync[i] | ~lock_mask[i]). If lock_mask is all zero, lock_ok=1.
- State encodings: WAIT_LOCK=0, STABLE=1, IDLY_RST=2, IDLY_WAIT=3, RELEASE=4, RUN=5, ERR=6.
- WAIT_LOCK: counter cleared. Moves to STABLE on the first cycle lock_ok=1. A lock_in rise therefore reaches STABLE on the 3rd sys_clk edge.
- STABLE: counter increments while lock_ok=1.
  - lock_ok=0 -> WAIT_LOCK.
  - counter==LOCK_STABLE_CYCLES-1 -> IDLY_RST.
- IDLY_RST: idelay_rst=1 for exactly IDELAY_RST_CYCLES cycles, then IDLY_WAIT; idelay_rst returns to 0 on entry to IDLY_WAIT.
- IDLY_WAIT: moves to RELEASE when rdy_sync=1. If rdy_sync is still 0 after RDY_TIMEOUT cycles -> ERR and timeout_err=1.
- RELEASE:
  - domain_rst[0] clears on the first RELEASE cycle.
  - domain_rst[k] clears k*STAGE_GAP cycles later.
  - After the last bit clears -> RUN on the following cycle.
  - Released bits stay 0 unless the sequence aborts.
- RUN: all_ready=1, domain_rst=0.
- Lock loss in any state except WAIT_LOCK and ERR -> WAIT_LOCK on the next edge. The same edge sets domain_rst to all 1s, idelay_rst=0 and all_ready=0, which aborts the IDELAY pulse mid-width.
- relock_count increments (saturating at 255) only on lock loss while in RUN.
- soft_rst=1 in any state -> WAIT_LOCK with the same output effects as lock loss, and clears timeout_err. It has priority over lock loss and does not increment relock_count.
- ERR: domain_rst all 1s, idelay_rst=0. Lock changes are ignored; only soft_rst or sys_rst leave ERR.
- Simultaneous: if rdy_sync rises on the same cycle the timeout expires, rdy wins (-> RELEASE).
- Masking a lost lock mid-sequence takes effect on the next cycle.

Optional Feature:
Macro ROACH_RST_SEQ_RELOCK_CNT_EN.
- Defined: relock_count is implemented as described above.
- Undefined: relock_count is tied to 0 and no counter logic is present; all other behaviour is identical.

Test Plan:
Use NUM_LOCKS=2, NUM_DOMAINS=3, LOCK_STABLE_CYCLES=8, IDELAY_RST_CYCLES=4, STAGE_GAP=5, RDY_TIMEOUT=20, lock_mask=2'b11, macro defined.
1. Nominal bring-up: release sys_rst, set lock_in=2'b11 at cycle 0, raise idelay_rdy at cycle 20 -> STABLE at cycle 3, idelay_rst high for cycles 11-14, domain_rst[0..2] clear at staged 5-cycle intervals, all_ready=1 one cycle after domain_rst[2] clears.
2. Glitchy lock: drop lock_in[1] for 1 cycle at STABLE count 5 -> return to WAIT_LOCK, counter restarts, idelay_rst not pulsed.
3. Masked lock: lock_mask=2'b01, lock_in=2'b01 -> full sequence completes, all_ready=1.
4. Timeout: idelay_rdy held 0 -> seq_state=6 and timeout_err=1 exactly 20 cycles after idelay_rst falls. soft_rst pulse -> timeout_err=0 and seq_state=0.
5. Relock: from RUN, drop lock_in[0] for 2 cycles -> domain_rst=3'b111 and all_ready=0 next edge, relock_count=1, sequence re-runs to RUN. Repeat 300 times -> relock_count=255.
6. Priority: assert soft_rst on the same cycle as lock loss in RUN -> WAIT_LOCK, relock_count unchanged. Assert sys_rst mid-RELEASE -> all outputs at reset values immediately.
